// File: rtl/led_chase_ctrl.sv
// rtl/led_chase_ctrl.sv - prescaled wrap/bounce 3-bit LED chase index generator
// Optional manual STEP input enabled by defining LED_CHASE_STEP_EN.
module led_chase_ctrl #(
    parameter int               DIV_W   = 24,
    parameter logic [DIV_W-1:0] DIV_MAX = 24'd12499999
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       DIR,
    input  logic       MODE,
    input  logic       LOAD,
    input  logic [2:0] LOAD_VAL,
`ifdef LED_CHASE_STEP_EN
    input  logic       STEP,
`endif
    output logic [2:0] IDX,
    output logic       TICK,
    output logic       WRAP
);

    typedef enum logic {S_UP = 1'b0, S_DOWN = 1'b1} state_t;

    state_t           state_q, state_d;
    state_t           dir_eff;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             do_step;
    logic             manual_step;

`ifdef LED_CHASE_STEP_EN
    logic step_q, step_prev_q;

    // Manual steps only count while the prescaler is held off.
    assign manual_step = step_q & ~step_prev_q & ~EN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            step_q      <= STEP;
            step_prev_q <= step_q;
        end
    end
`else
    assign manual_step = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_UP;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        do_step = 1'b0;
        // Wrap mode follows DIR immediately so a bounce->wrap switch re-syncs at once.
        dir_eff = MODE ? state_q : (DIR ? S_DOWN : S_UP);

        if (EN) begin
            if (cnt_q == DIV_MAX) begin
                cnt_d   = '0;
                do_step = 1'b1;
            end else begin
                cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
        if (manual_step)
            do_step = 1'b1;

        if (!MODE)
            state_d = dir_eff;

        if (do_step) begin
            tick_d = 1'b1;
            if (!MODE) begin
                if (dir_eff == S_UP) begin
                    idx_d  = idx_q + 3'd1;
                    wrap_d = (idx_q == 3'd7);
                end else begin
                    idx_d  = idx_q - 3'd1;
                    wrap_d = (idx_q == 3'd0);
                end
            end else if (state_q == S_UP) begin
                if (idx_q == 3'd7) begin
                    idx_d   = 3'd6;
                    state_d = S_DOWN;
                    wrap_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end else begin
                if (idx_q == 3'd0) begin
                    idx_d   = 3'd1;
                    state_d = S_UP;
                    wrap_d  = 1'b1;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
        end

        if (LOAD) begin
            idx_d   = LOAD_VAL;
            cnt_d   = '0;
            state_d = DIR ? S_DOWN : S_UP;
            tick_d  = 1'b0;
            wrap_d  = 1'b0;
        end
    end

    always_comb begin
        IDX  = idx_q;
        TICK = tick_q;
        WRAP = wrap_q;
    end

endmodule

// File: tb/tb_led_chase_ctrl.sv
// tb/tb_led_chase_ctrl.sv - randomized bench for led_chase_ctrl against a position/direction model
module tb_led_chase_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       DIR = 1'b0;
    logic       MODE = 1'b0;
    logic       LOAD = 1'b0;
    logic [2:0] LOAD_VAL = 3'd0;
    logic       STEP = 1'b0;
    logic [2:0] idx_a, idx_b;
    logic       tick_a, tick_b, wrap_a, wrap_b;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: index 0 -> DIV_MAX=3 instance, index 1 -> DIV_MAX=0 instance.
    int m_pos [2];
    int m_cnt [2];
    int m_heading [2];
    int m_tick [2];
    int m_wrap [2];
    int div_max [2] = '{3, 0};

    always #5 CLK = ~CLK;

    led_chase_ctrl #(.DIV_W(24), .DIV_MAX(24'd3)) u_dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .MODE(MODE),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
`ifdef LED_CHASE_STEP_EN
        .STEP(STEP),
`endif
        .IDX(idx_a), .TICK(tick_a), .WRAP(wrap_a)
    );

    led_chase_ctrl #(.DIV_W(24), .DIV_MAX(24'd0)) u_dut0 (
        .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .MODE(MODE),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
`ifdef LED_CHASE_STEP_EN
        .STEP(STEP),
`endif
        .IDX(idx_b), .TICK(tick_b), .WRAP(wrap_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Position moves by heading (+1/-1); ends are where the walk turns or wraps.
    task automatic model_edge(input int k);
        m_tick[k] = 0;
        m_wrap[k] = 0;
        if (RST) begin
            m_pos[k] = 0; m_cnt[k] = 0; m_heading[k] = 1;
        end else if (LOAD) begin
            m_pos[k] = LOAD_VAL; m_cnt[k] = 0; m_heading[k] = DIR ? -1 : 1;
        end else begin
            if (!MODE) m_heading[k] = DIR ? -1 : 1;
            if (EN) begin
                if (m_cnt[k] < div_max[k]) begin
                    m_cnt[k]++;
                end else begin
                    m_cnt[k] = 0;
                    m_tick[k] = 1;
                    if (!MODE) begin
                        m_wrap[k] = (m_pos[k] + m_heading[k] < 0 || m_pos[k] + m_heading[k] > 7) ? 1 : 0;
                        m_pos[k] = (m_pos[k] + m_heading[k] + 8) % 8;
                    end else begin
                        if (m_pos[k] + m_heading[k] < 0 || m_pos[k] + m_heading[k] > 7) begin
                            m_heading[k] = -m_heading[k];
                            m_wrap[k] = 1;
                        end
                        m_pos[k] = m_pos[k] + m_heading[k];
                    end
                end
            end
        end
    endtask

    task automatic run_cycle();
        @(posedge CLK);
        model_edge(0);
        model_edge(1);
        #1;
        check("idx_div3", int'(idx_a), m_pos[0]);
        check("tick_div3", int'(tick_a), m_tick[0]);
        check("wrap_div3", int'(wrap_a), m_wrap[0]);
        check("idx_div0", int'(idx_b), m_pos[1]);
        check("tick_div0", int'(tick_b), m_tick[1]);
        check("wrap_div0", int'(wrap_b), m_wrap[1]);
    endtask

    initial begin
        // Reset held two cycles with EN already high.
        RST = 1'b1; EN = 1'b1;
        run_cycle();
        run_cycle();
        check("reset_idx", int'(idx_a), 0);
        check("reset_tick", int'(tick_a), 0);
        check("reset_wrap", int'(wrap_a), 0);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();
        check("first_step_idx", int'(idx_a), 1);
        check("first_step_tick", int'(tick_a), 1);

        // Wrap mode up, then down through 0->7.
        for (int i = 0; i < 40; i++) run_cycle();
        DIR = 1'b1;
        for (int i = 0; i < 2; i++) run_cycle();
        EN = 1'b0;
        for (int i = 0; i < 10; i++) run_cycle();
        EN = 1'b1;
        for (int i = 0; i < 40; i++) run_cycle();

        // Bounce from 5.
        MODE = 1'b1; DIR = 1'b0; LOAD = 1'b1; LOAD_VAL = 3'd5;
        run_cycle();
        LOAD = 1'b0;
        for (int i = 0; i < 70; i++) run_cycle();

        // Load on a step edge, then reset mid-run.
        MODE = 1'b0;
        while (u_dut.cnt_q != 24'd3 && n_cmp < 100000) run_cycle();
        LOAD = 1'b1; LOAD_VAL = 3'd3;
        run_cycle();
        check("load_on_tick_idx", int'(idx_a), 3);
        check("load_on_tick_tick", int'(tick_a), 0);
        LOAD = 1'b0;
        for (int i = 0; i < 6; i++) run_cycle();
        RST = 1'b1;
        run_cycle();
        check("rst_run_idx", int'(idx_a), 0);
        RST = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            EN       = ($urandom_range(0, 7) != 0);
            LOAD     = ($urandom_range(0, 39) == 0);
            LOAD_VAL = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) MODE = ~MODE;
            if ($urandom_range(0, 29) == 0) DIR = ~DIR;
            RST      = ($urandom_range(0, 299) == 0);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
